// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state encoding for the boot-time instruction memory loader.
package imem_loader_pkg;

    localparam int unsigned ADDR_W         = 5;
    localparam int unsigned DEPTH          = 2 ** ADDR_W;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned FRAME_MAX      = DEPTH;
    localparam int unsigned BYTES_PER_WORD = 4;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StWrite,
        StCsum,
        StDone,
        StError
    } state_e;

endpackage

// File: rtl/loader_word_asm.sv
// Little-endian word assembler: shifts bytes into lanes and keeps a running XOR checksum.
module loader_word_asm
    import imem_loader_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] word_o,
    output logic [7:0]        csum_o,
    output logic              word_done_o
);

    logic [DATA_W-1:0] word_q, word_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [7:0]        csum_q, csum_d;

    always_comb begin
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        csum_d     = csum_q;
        if (clear_i) begin
            word_d     = '0;
            byte_cnt_d = '0;
            csum_d     = '0;
        end else if (load_i) begin
            word_d[8*byte_cnt_q +: 8] = byte_i;
            byte_cnt_d                = byte_cnt_q + 2'd1;
            csum_d                    = csum_q ^ byte_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q     <= '0;
            byte_cnt_q <= '0;
            csum_q     <= '0;
        end else begin
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            csum_q     <= csum_d;
        end
    end

    assign word_o      = word_q;
    assign csum_o      = csum_q;
    assign word_done_o = load_i && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes words into instruction memory and holds the core
// in reset until a frame with a good checksum has been loaded.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned AddrW = ADDR_W,
    parameter int unsigned Depth = FRAME_MAX
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [7:0]        byte_data_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic [AddrW-1:0]  imem_addr_o,
    output logic [DATA_W-1:0] imem_data_o,
    output logic              imem_rw_o,
    output logic              loading_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              error_o
);

    state_e            state_q, state_d;
    logic [AddrW:0]    word_cnt_q, word_cnt_d;
    logic [AddrW:0]    len_q, len_d;
    logic [AddrW:0]    word_cnt_inc;
    logic              xfer;
    logic              asm_clear;
    logic              asm_load;
    logic              word_done;
    logic [7:0]        csum;
    logic [DATA_W-1:0] word;
    logic              len_bad;

    assign byte_ready_o = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
    assign xfer         = byte_valid_i && byte_ready_o;
    assign word_cnt_inc = word_cnt_q + 1'b1;
    assign len_bad      = (byte_data_i == 8'd0) || ({24'd0, byte_data_i} > Depth);
    assign imem_data_o  = word;

    loader_word_asm u_word_asm (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (asm_clear),
        .load_i      (asm_load),
        .byte_i      (byte_data_i),
        .word_o      (word),
        .csum_o      (csum),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        asm_clear   = 1'b0;
        asm_load    = 1'b0;
        imem_rw_o   = RW_READ;
        imem_addr_o = '0;
        loading_o   = 1'b0;
        cpu_hold_o  = 1'b1;
        done_o      = 1'b0;
        error_o     = 1'b0;

        unique case (state_q)
            StIdle, StDone, StError: begin
                if (state_q == StDone) begin
                    cpu_hold_o = 1'b0;
                    done_o     = 1'b1;
                end
                error_o = (state_q == StError);
                if (start_i) begin
                    state_d    = StLen;
                    asm_clear  = 1'b1;
                    word_cnt_d = '0;
                    len_d      = '0;
                end
            end
            StLen: begin
                loading_o = 1'b1;
                if (xfer) begin
                    if (len_bad) begin
                        state_d = StError;
                    end else begin
                        len_d   = byte_data_i[AddrW:0];
                        state_d = StData;
                    end
                end
            end
            StData: begin
                loading_o = 1'b1;
                asm_load  = xfer;
                if (word_done) state_d = StWrite;
            end
            StWrite: begin
                loading_o   = 1'b1;
                imem_rw_o   = RW_WRITE;
                imem_addr_o = word_cnt_q[AddrW-1:0];
                word_cnt_d  = word_cnt_inc;
                state_d     = (word_cnt_inc == len_q) ? StCsum : StData;
            end
            StCsum: begin
                loading_o = 1'b1;
                if (xfer) state_d = (byte_data_i == csum) ? StDone : StError;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a frame-level reference model.
module tb_imem_loader;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [7:0]  byte_data_i;
    logic        byte_valid_i;
    logic        byte_ready_o;
    logic [4:0]  imem_addr_o;
    logic [31:0] imem_data_o;
    logic        imem_rw_o;
    logic        loading_o;
    logic        cpu_hold_o;
    logic        done_o;
    logic        error_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  frame_q[$];
    logic [4:0]  obs_addr[$];
    logic [31:0] obs_data[$];
    logic        prev_rw = 1'b1;

    imem_loader dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .byte_data_i  (byte_data_i),
        .byte_valid_i (byte_valid_i),
        .byte_ready_o (byte_ready_o),
        .imem_addr_o  (imem_addr_o),
        .imem_data_o  (imem_data_o),
        .imem_rw_o    (imem_rw_o),
        .loading_o    (loading_o),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every write is a lone cycle with the byte interface stalled.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && imem_rw_o === 1'b0) begin
            check("wr_ready_low", {63'd0, byte_ready_o}, 64'd0);
            check("wr_not_consec", {63'd0, prev_rw}, 64'd1);
            obs_addr.push_back(imem_addr_o);
            obs_data.push_back(imem_data_o);
        end
        prev_rw = imem_rw_o;
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, {63'd0, byte_ready_o}, 64'd0);
        check({tag, "_addr"}, {59'd0, imem_addr_o}, 64'd0);
        check({tag, "_data"}, {32'd0, imem_data_o}, 64'd0);
        check({tag, "_rw"}, {63'd0, imem_rw_o}, 64'd1);
        check({tag, "_loading"}, {63'd0, loading_o}, 64'd0);
        check({tag, "_hold"}, {63'd0, cpu_hold_o}, 64'd1);
        check({tag, "_done"}, {63'd0, done_o}, 64'd0);
        check({tag, "_error"}, {63'd0, error_o}, 64'd0);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok = 1'b0;
        if (gaps) begin
            byte_valid_i = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
        end
        byte_data_i  = b;
        byte_valid_i = 1'b1;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (byte_ready_o) begin
                @(posedge clk_i);
                ok = 1'b1;
            end else begin
                @(negedge clk_i);
            end
        end
        #1;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'($urandom);
        @(negedge clk_i);
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic build_frame(input int n, input bit corrupt);
        logic [7:0] b;
        logic [7:0] cs = 8'd0;
        frame_q.delete();
        frame_q.push_back(8'(n));
        if (n == 0 || n > 32) return;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            cs ^= b;
            frame_q.push_back(b);
        end
        frame_q.push_back(corrupt ? (cs ^ 8'($urandom_range(1, 255))) : cs);
    endtask

    // Sends frame_q after a start pulse and checks the outcome from frame contents alone.
    task automatic run_frame(input string tag, input bit gaps);
        int          n;
        logic [7:0]  cs;
        bit          good;
        logic [31:0] w;
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        check({tag, "_loading"}, {63'd0, loading_o}, 64'd1);
        n = int'(frame_q[0]);
        send_byte(frame_q[0], gaps);
        if (n == 0 || n > 32) begin
            repeat (3) @(negedge clk_i);
            check({tag, "_len_err"}, {63'd0, error_o}, 64'd1);
            check({tag, "_len_done"}, {63'd0, done_o}, 64'd0);
            check({tag, "_len_hold"}, {63'd0, cpu_hold_o}, 64'd1);
            check({tag, "_len_writes"}, 64'(obs_addr.size()), 64'd0);
            return;
        end
        for (int i = 1; i < frame_q.size(); i++) send_byte(frame_q[i], gaps);
        cs = 8'd0;
        for (int i = 1; i <= 4 * n; i++) cs ^= frame_q[i];
        good = (cs == frame_q[4 * n + 1]);
        check({tag, "_done"}, {63'd0, done_o}, {63'd0, good});
        check({tag, "_error"}, {63'd0, error_o}, {63'd0, !good});
        check({tag, "_hold"}, {63'd0, cpu_hold_o}, {63'd0, !good});
        check({tag, "_loading"}, {63'd0, loading_o}, 64'd0);
        check({tag, "_rw_idle"}, {63'd0, imem_rw_o}, 64'd1);
        check({tag, "_nwrites"}, 64'(obs_addr.size()), 64'(n));
        for (int i = 0; i < n && i < obs_addr.size(); i++) begin
            w = {frame_q[4*i+4], frame_q[4*i+3], frame_q[4*i+2], frame_q[4*i+1]};
            check({tag, "_waddr"}, {59'd0, obs_addr[i]}, 64'(i));
            check({tag, "_wdata"}, {32'd0, obs_data[i]}, {32'd0, w});
        end
    endtask

    initial begin
        logic [7:0] fixed[10];
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_data_i  = 8'h00;
        repeat (2) @(negedge clk_i);
        check_reset_vals("rst");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check_reset_vals("idle");

        // Fixed 2-word frame with hand-written words
        fixed = '{8'h02, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        fixed[9] = 8'h78 ^ 8'h56 ^ 8'h34 ^ 8'h12 ^ 8'hEF ^ 8'hBE ^ 8'hAD ^ 8'hDE;
        frame_q.delete();
        foreach (fixed[i]) frame_q.push_back(fixed[i]);
        run_frame("good2", 1'b0);
        if (obs_data.size() == 2) begin
            check("good2_w0", {32'd0, obs_data[0]}, 64'h12345678);
            check("good2_w1", {32'd0, obs_data[1]}, 64'hDEADBEEF);
        end else begin
            check("good2_count", 64'(obs_data.size()), 64'd2);
        end
        repeat (2) @(negedge clk_i);
        check("done_level", {63'd0, done_o}, 64'd1);

        // Same frame, checksum flipped
        frame_q[9] = fixed[9] ^ 8'hFF;
        run_frame("badcs", 1'b0);

        build_frame(0, 1'b0);
        run_frame("len0", 1'b0);
        build_frame(33, 1'b0);
        run_frame("len33", 1'b1);

        build_frame(32, 1'b0);
        run_frame("max32", 1'b1);

        for (int k = 0; k < 6; k++) begin
            build_frame($urandom_range(1, 32), ($urandom_range(0, 2) == 0));
            run_frame("rand", 1'b1);
        end

        // start mid-DATA must be ignored and the frame completes normally
        build_frame(2, 1'b0);
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(frame_q[i], 1'b0);
        pulse_start();
        check("ign_start_loading", {63'd0, loading_o}, 64'd1);
        check("ign_start_ready", {63'd0, byte_ready_o}, 64'd1);
        for (int i = 6; i < frame_q.size(); i++) send_byte(frame_q[i], 1'b0);
        check("ign_start_done", {63'd0, done_o}, 64'd1);
        check("ign_start_nwrites", 64'(obs_addr.size()), 64'd2);
        if (obs_data.size() == 2)
            check("ign_start_w1", {32'd0, obs_data[1]},
                  {32'd0, frame_q[8], frame_q[7], frame_q[6], frame_q[5]});

        // Reset mid-frame, then a fresh 1-word frame
        build_frame(2, 1'b0);
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(frame_q[i], 1'b0);
        rst_ni = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        build_frame(1, 1'b0);
        run_frame("after_rst", 1'b0);

        repeat (3) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Boot-time program loader sitting directly upstream of the instruction memory. It accepts a framed byte stream (from the UART receiver), assembles little-endian 32-bit words and writes them into instruction memory through its write port (rw=0 write, rw=1 read). It holds the core in reset until a frame is loaded and verified, then releases the memory port and the core.

Parameters:
ADDR_W, 5, instruction memory address width
DEPTH, 32, max words per frame (2**ADDR_W)
DATA_W, 32, word width; fixed 4 bytes per word

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse: begin a new load (ignored unless IDLE, DONE or ERROR)
byte_data  in  8  incoming stream byte
byte_valid  in  1  byte_data valid
byte_ready  out  1  loader can accept a byte this cycle
imem_addr  out  ADDR_W  address to instruction memory
imem_data  out  DATA_W  write data to instruction memory
imem_rw  out  1  0 = write, 1 = read; idle value 1
loading  out  1  loader owns memory port; core must not fetch
cpu_hold  out  1  1 = keep core in reset
done  out  1  frame loaded and checksum good (level)
error  out  1  bad length or checksum mismatch (level)

Behaviour:
- Reset (async, reset_n=0): state IDLE; imem_addr=0, imem_data=0, imem_rw=1, byte_ready=0, loading=0, cpu_hold=1, done=0, error=0; word/byte counters and checksum cleared.
- Byte transfer occurs on a rising edge where byte_valid & byte_ready; otherwise byte_data ignored.
- Frame: byte 0 = N (word count, 1..DEPTH); then 4*N data bytes, least-significant first; then 1 checksum byte = XOR of all 4*N data bytes.
- States: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR.
- IDLE/DONE/ERROR --start--> LEN; entering LEN clears done, error, counters, checksum; loading=1, cpu_hold=1.
- LEN: byte_ready=1. On transfer: N=0 or N>DEPTH -> ERROR; else latch N -> DATA.
- DATA: byte_ready=1. Each transfer shifts byte into lane [byte_cnt]; checksum ^= byte. After 4th byte of a word -> WRITE.
- WRITE: exactly one cycle; byte_ready=0; imem_rw=0, imem_addr=word_cnt, imem_data=assembled word. Next cycle imem_rw returns to 1; word_cnt+1; if word_cnt+1==N -> CSUM else DATA.
- CSUM: byte_ready=1. On transfer: match -> DONE, else ERROR.
- DONE: loading=0, cpu_hold=0, done=1, imem_addr=0, imem_rw=1.
- ERROR: error=1, cpu_hold=1, loading=0, imem_rw=1. Words already written stay in memory; only a new start recovers.
- imem_rw is 0 only in WRITE; never two consecutive write cycles. Addresses written are 0..N-1 in order; word_cnt never wraps (N<=DEPTH checked).
- start while in LEN/DATA/WRITE/CSUM: ignored.
- byte_valid held low mid-frame: state holds indefinitely (no timeout).
- reset_n asserted mid-frame: immediate return to reset values; partial frame abandoned; memory content undefined.
- Latency: last data byte transfer -> write cycle on next clock; checksum byte transfer -> done=1 next clock.

Decomposition:
- Shared package: state encoding, FRAME_MAX=DEPTH, BYTES_PER_WORD=4, rw encoding constants (RW_WRITE=0, RW_READ=1).
- One natural sub-module: loader_word_asm (byte-lane shift register + 2-bit byte counter + XOR checksum accumulator, with clear and load-enable). FSM stays in imem_loader.

Test Plan:
- Reset then idle: reset_n low mid-run -> all outputs at reset values, imem_rw=1, cpu_hold=1, byte_ready=0.
- Good 2-word frame: start; bytes 02, 78 56 34 12, EF BE AD DE, checksum 0x00^...=0x44^... (computed XOR) -> writes addr0=0x12345678, addr1=0xDEADBEEF, each a single rw=0 cycle; done=1, cpu_hold=0.
- Bad checksum: same frame with checksum byte flipped -> both words written, error=1, done=0, cpu_hold=1.
- Bad length: N=0x00 and N=0x21 -> ERROR after length byte, no rw=0 cycle ever.
- Max frame with gaps: N=32, random byte_valid gaps -> addresses 0..31 written in order, no wrap, byte_ready=0 during each WRITE cycle, done=1.
- Reset mid-frame and restart: reset_n pulse after 5 data bytes, then full 1-word frame -> only new word at addr0, done=1; start during DATA ignored.
